// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - Push/pop/status bundle between the UART receiver side and the RX FIFO
// The slave modport is the FIFO itself. The master modport is the receiver plus the consumer.
interface uart_rx_fifo_if #(
    parameter int WORD_BITS = 8,
    parameter int ADDR_BITS = 4
);
    logic                 wr_i;
    logic [WORD_BITS-1:0] wr_data_i;
    logic                 rd_i;
    logic                 ovf_clr_i;
    logic [WORD_BITS-1:0] rd_data_o;
    logic                 empty_o;
    logic                 full_o;
    logic [ADDR_BITS:0]   count_o;
    logic                 overflow_o;

    modport master (
        output wr_i,
        output wr_data_i,
        output rd_i,
        output ovf_clr_i,
        input  rd_data_o,
        input  empty_o,
        input  full_o,
        input  count_o,
        input  overflow_o
    );

    modport slave (
        input  wr_i,
        input  wr_data_i,
        input  rd_i,
        input  ovf_clr_i,
        output rd_data_o,
        output empty_o,
        output full_o,
        output count_o,
        output overflow_o
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - First-word-fall-through receive FIFO with sticky overflow flag
// Pointers carry one extra wrap bit so that full and empty can be told apart without a counter.
module uart_rx_fifo #(
    parameter int WORD_BITS = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    uart_rx_fifo_if.slave   bus
);
    logic [WORD_BITS-1:0] r_mem [2**ADDR_BITS];
    logic [ADDR_BITS:0]   r_wr_ptr;
    logic [ADDR_BITS:0]   r_rd_ptr;
    logic                 r_ovf;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_ovf_set;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_BITS] != r_rd_ptr[ADDR_BITS]) &&
                     (r_wr_ptr[ADDR_BITS-1:0] == r_rd_ptr[ADDR_BITS-1:0]);

    // A pop on a full FIFO frees a slot on the same edge, so the push may proceed.
    assign w_push    = bus.wr_i && (!w_full || bus.rd_i);
    assign w_pop     = bus.rd_i && !w_empty;
    assign w_ovf_set = bus.wr_i && w_full && !bus.rd_i;

    // Storage is deliberately not reset; empty_o masks stale contents on the read port.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_BITS-1:0]] <= bus.wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // A dropped push in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (bus.ovf_clr_i) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.empty_o    = w_empty;
    assign bus.full_o     = w_full;
    assign bus.count_o    = r_wr_ptr - r_rd_ptr;
    assign bus.overflow_o = r_ovf;
    assign bus.rd_data_o  = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_BITS-1:0]];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - Randomized, model-checked bench for uart_rx_fifo
// A queue model predicts every output; a negedge process compares DUT against it each cycle.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;

    logic clk_i;
    logic reset_n_i;

    uart_rx_fifo_if #(.WORD_BITS(8), .ADDR_BITS(4)) bus ();

    uart_rx_fifo #(.WORD_BITS(8), .ADDR_BITS(4)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_q [$];
    logic       m_ovf = 1'b0;
    logic       cmp_en = 1'b0;
    int         max_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] m_head();
        return (m_q.size() != 0) ? m_q[0] : 8'h00;
    endfunction

    // Applies one cycle of inputs, advances the model on the same edge, then idles the strobes.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic was_full;
        logic was_empty;
        bus.wr_i      = w;
        bus.wr_data_i = d;
        bus.rd_i      = r;
        bus.ovf_clr_i = c;
        @(posedge clk_i);
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        if (w && was_full && !r) m_ovf = 1'b1;
        else if (c)              m_ovf = 1'b0;
        if (r && !was_empty) void'(m_q.pop_front());
        if (w && (!was_full || r)) m_q.push_back(d);
        if (m_q.size() > max_count) max_count = m_q.size();
        #1;
        bus.wr_i      = 1'b0;
        bus.rd_i      = 1'b0;
        bus.ovf_clr_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (cmp_en) begin
            chk("cyc_empty",    32'(bus.empty_o),    32'(m_q.size() == 0));
            chk("cyc_full",     32'(bus.full_o),     32'(m_q.size() == DEPTH));
            chk("cyc_count",    32'(bus.count_o),    32'(m_q.size()));
            chk("cyc_overflow", 32'(bus.overflow_o), 32'(m_ovf));
            chk("cyc_rd_data",  32'(bus.rd_data_o),  32'(m_head()));
        end
    end

    initial begin
        reset_n_i     = 1'b0;
        bus.wr_i      = 1'b0;
        bus.wr_data_i = 8'h00;
        bus.rd_i      = 1'b0;
        bus.ovf_clr_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        cmp_en    = 1'b1;

        // Reset state after idle
        repeat (5) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_empty",    32'(bus.empty_o),    32'd1);
        chk("rst_full",     32'(bus.full_o),     32'd0);
        chk("rst_count",    32'(bus.count_o),    32'd0);
        chk("rst_rd_data",  32'(bus.rd_data_o),  32'd0);
        chk("rst_overflow", 32'(bus.overflow_o), 32'd0);

        // Single word latency, then pop back to empty
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("one_empty",   32'(bus.empty_o),   32'd0);
        chk("one_rd_data", 32'(bus.rd_data_o), 32'hA5);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("one_pop_empty", 32'(bus.empty_o),   32'd1);
        chk("one_pop_data",  32'(bus.rd_data_o), 32'd0);

        // Fill, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        chk("ovf_full",  32'(bus.full_o),     32'd1);
        chk("ovf_count", 32'(bus.count_o),    32'd16);
        chk("ovf_flag",  32'(bus.overflow_o), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", 32'(bus.rd_data_o), 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(bus.empty_o), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(bus.overflow_o), 32'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        chk("fullrw_count", 32'(bus.count_o),    32'd16);
        chk("fullrw_ovf",   32'(bus.overflow_o), 32'd0);
        chk("fullrw_head",  32'(bus.rd_data_o),  32'h11);
        for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fullrw_last", 32'(bus.rd_data_o), 32'h77);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fullrw_empty", 32'(bus.empty_o), 32'd1);

        // Interleaved traffic wrapping the pointers several times
        for (int i = 0; i < 60; i++) begin
            cyc(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            if (($urandom_range(0, 2)) == 0) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_empty", 32'(bus.empty_o), 32'd1);

        // Fully random including overflow and clears
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 8'($urandom),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
        end
        chk("max_count_bound", 32'(max_count <= DEPTH), 32'd1);

        // Clear and dropped push in the same cycle: set wins
        while (m_q.size() < DEPTH) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(bus.overflow_o), 32'd1);

        // Asynchronous reset with three words held
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h31, 1'b0, 1'b0);
        cyc(1'b1, 8'h32, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(bus.count_o), 32'd3);
        #1;
        reset_n_i = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        #1;
        chk("arst_empty",    32'(bus.empty_o),    32'd1);
        chk("arst_full",     32'(bus.full_o),     32'd0);
        chk("arst_count",    32'(bus.count_o),    32'd0);
        chk("arst_rd_data",  32'(bus.rd_data_o),  32'd0);
        chk("arst_overflow", 32'(bus.overflow_o), 32'd0);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        cyc(1'b1, 8'h42, 1'b0, 1'b0);
        chk("post_rst_data", 32'(bus.rd_data_o), 32'h42);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
